// File: rtl/mem_pkg.sv
// Shared definitions for the banked main-memory responder and the cache controller
// that drives it: bank-select field, timing defaults and request-kind encoding.
package mem_pkg;

  localparam int BANK_SEL_LO   = 1;
  localparam int BANK_SEL_HI   = 2;
  localparam int NUM_BANKS     = 4;
  localparam int DEF_BANK_BUSY = 4;
  localparam int DEF_RD_LAT    = 2;

  // Matches the {wr, rd} pair the cache controller presents
  typedef enum logic [1:0] {
    REQ_NONE  = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10
  } reqKind_t;

  function automatic logic [1:0] bankOf(input logic [15:0] byteAddr);
    return byteAddr[BANK_SEL_HI:BANK_SEL_LO];
  endfunction

endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bus between a requester (cache controller or bench) and the
// banked memory responder.
interface banked_mem_responder_if;
  import mem_pkg::*;

  logic [15:0]          addr;
  logic [15:0]          data_in;
  logic                 wr;
  logic                 rd;
  logic [15:0]          data_out;
  logic                 done;
  logic                 stall;
  logic [NUM_BANKS-1:0] busy;
  logic                 err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, done, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, done, stall, busy, err
  );

endinterface

// File: rtl/banked_mem_responder_bank_occ_ctr.sv
// Per-bank occupancy counter: loads on an accepted access, counts down to zero
// and holds there; the bank is busy while the count is non-zero.
module bank_occ_ctr #(
  parameter int LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_busy
);

  localparam int CTR_W = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1);

  logic [CTR_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CTR_W'(LOAD_VAL);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank word-interleaved memory responder: one request per cycle, per-bank
// occupancy stalls, fixed-latency in-order read return.
module banked_mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_WORD_BITS = 15,
  parameter int BANK_BUSY     = DEF_BANK_BUSY,
  parameter int RD_LAT        = DEF_RD_LAT
) (
  input logic                    clk,
  input logic                    rst,
  banked_mem_responder_if.slave  io_bus
);

  logic [15:0]              r_mem [2**MEM_WORD_BITS];
  logic [RD_LAT-1:0]        r_pipeValid;
  logic [15:0]              r_pipeData [RD_LAT];

  logic [MEM_WORD_BITS-1:0] w_wordIdx;
  logic [1:0]               w_bank;
  logic [NUM_BANKS-1:0]     w_busy;
  logic                     w_legal;
  logic                     w_err;
  logic                     w_stall;
  logic                     w_accept;

  assign w_wordIdx = io_bus.addr[MEM_WORD_BITS:1];
  assign w_bank    = bankOf(io_bus.addr);
  assign w_legal   = (io_bus.rd ^ io_bus.wr) & ~io_bus.addr[0];
  assign w_err     = (io_bus.rd & io_bus.wr) | ((io_bus.rd | io_bus.wr) & io_bus.addr[0]);
  assign w_stall   = w_legal & w_busy[w_bank];
  assign w_accept  = w_legal & ~w_stall & ~rst;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_occ_ctr #(
      .LOAD_VAL (BANK_BUSY - 1)
    ) u_occ (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept && (w_bank == 2'(b))),
      .o_busy (w_busy[b])
    );
  end

  // Array is deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) begin
    if (w_accept && io_bus.wr) begin
      r_mem[w_wordIdx] <= io_bus.data_in;
    end
  end

  // Invalid stages carry zero data so the last stage can drive data_out directly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipeValid <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        r_pipeData[s] <= '0;
      end
    end else begin
      r_pipeValid[0] <= w_accept & io_bus.rd;
      r_pipeData[0]  <= (w_accept && io_bus.rd) ? r_mem[w_wordIdx] : 16'h0000;
      for (int s = 1; s < RD_LAT; s++) begin
        r_pipeValid[s] <= r_pipeValid[s-1];
        r_pipeData[s]  <= r_pipeData[s-1];
      end
    end
  end

  assign io_bus.done     = r_pipeValid[RD_LAT-1];
  assign io_bus.data_out = r_pipeData[RD_LAT-1];
  assign io_bus.stall    = w_stall;
  assign io_bus.err      = w_err;
  assign io_bus.busy     = w_busy;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Randomized self-checking bench: a cycle-numbered model tracks when each bank
// frees up and when each accepted read must return.
module tb_banked_mem_responder;
  import mem_pkg::*;

  localparam int BANK_BUSY = 4;
  localparam int RD_LAT    = 2;

  typedef struct {
    int          due;
    logic [15:0] data;
  } pendRead_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  banked_mem_responder_if bus ();

  banked_mem_responder #(
    .MEM_WORD_BITS (15),
    .BANK_BUSY     (BANK_BUSY),
    .RD_LAT        (RD_LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int          checkCount = 0;
  int          errCount   = 0;
  int          cyc        = 0;
  int          freeAt [4];
  logic [15:0] refMem [int];
  pendRead_t   pend [$];
  logic [15:0] pool [16];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  // One clock cycle: drive the request, compare every output to the model, then
  // advance the model across the closing edge.
  task automatic applyStimulus(input reqKind_t kind, input logic both,
                               input logic [15:0] iAddr, input logic [15:0] iData,
                               input logic iRst, output logic stalled);
    logic        iRd, iWr, eErr, eLegal, eStall, eDone;
    logic [15:0] eData;
    logic [3:0]  eBusy;
    int          bank, idx;
    @(posedge clk);
    #1;
    cyc++;
    iRd = both | (kind == REQ_READ);
    iWr = both | (kind == REQ_WRITE);
    bus.rd = iRd;
    bus.wr = iWr;
    bus.addr = iAddr;
    bus.data_in = iData;
    rst = iRst;
    #1;
    eDone = 1'b0;
    eData = 16'h0000;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      eDone = 1'b1;
      eData = pend[0].data;
      void'(pend.pop_front());
    end
    for (int b = 0; b < 4; b++) eBusy[b] = (cyc < freeAt[b]);
    bank   = int'(iAddr[2:1]);
    idx    = int'(iAddr[15:1]);
    eErr   = (iRd & iWr) | ((iRd | iWr) & iAddr[0]);
    eLegal = (iRd ^ iWr) & ~iAddr[0];
    eStall = eLegal & eBusy[bank];
    checkOutput("done", 32'(bus.done), 32'(eDone));
    checkOutput("data_out", 32'(bus.data_out), 32'(eData));
    checkOutput("busy", 32'(bus.busy), 32'(eBusy));
    checkOutput("stall", 32'(bus.stall), 32'(eStall));
    checkOutput("err", 32'(bus.err), 32'(eErr));
    if (iRst) begin
      pend.delete();
      for (int b = 0; b < 4; b++) freeAt[b] = 0;
    end else if (eLegal && !eStall) begin
      freeAt[bank] = cyc + BANK_BUSY;
      if (iWr) refMem[idx] = iData;
      else pend.push_back('{cyc + RD_LAT, refMem.exists(idx) ? refMem[idx] : 16'h0000});
    end
    stalled = eStall;
  endtask

  // Requester behaviour: hold the request until the model says it was taken
  task automatic issueHeld(input reqKind_t kind, input logic [15:0] iAddr,
                           input logic [15:0] iData);
    logic stalled;
    int   tries = 0;
    do begin
      applyStimulus(kind, 1'b0, iAddr, iData, 1'b0, stalled);
      tries++;
    end while (stalled && tries < 10);
    if (stalled) checkOutput("holdBound", 32'(tries), 32'(BANK_BUSY));
  endtask

  task automatic idle(input int n);
    logic stalled;
    for (int i = 0; i < n; i++) applyStimulus(REQ_NONE, 1'b0, 16'h0, 16'h0, 1'b0, stalled);
  endtask

  initial begin
    logic     stalled;
    reqKind_t k;
    int       sel;
    logic [15:0] a;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.addr = 16'h0;
    bus.data_in = 16'h0;
    for (int b = 0; b < 4; b++) freeAt[b] = 0;
    repeat (2) @(posedge clk);

    // Reset values, then write/read round trip with latency
    applyStimulus(REQ_NONE, 1'b0, 16'h0, 16'h0, 1'b1, stalled);
    issueHeld(REQ_WRITE, 16'h0010, 16'h1234);
    idle(3);
    issueHeld(REQ_READ, 16'h0010, 16'h0);
    idle(3);

    // Back-to-back writes and reads across all four banks
    for (int i = 0; i < 4; i++) issueHeld(REQ_WRITE, 16'(2 * i), 16'hA0A0 + 16'(i));
    for (int i = 0; i < 4; i++) issueHeld(REQ_READ, 16'(2 * i), 16'h0);
    idle(4);

    // Bank conflict
    issueHeld(REQ_WRITE, 16'h0000, 16'h5A5A);
    issueHeld(REQ_READ, 16'h0008, 16'h0);
    idle(4);

    // Illegal requests leave everything untouched
    applyStimulus(REQ_NONE, 1'b1, 16'h0004, 16'hDEAD, 1'b0, stalled);
    applyStimulus(REQ_READ, 1'b0, 16'h0003, 16'h0, 1'b0, stalled);
    idle(4);
    issueHeld(REQ_READ, 16'h0004, 16'h0);
    idle(3);

    // Reset with a read in flight
    issueHeld(REQ_READ, 16'h0010, 16'h0);
    applyStimulus(REQ_NONE, 1'b0, 16'h0, 16'h0, 1'b1, stalled);
    idle(4);
    issueHeld(REQ_READ, 16'h0010, 16'h0);
    idle(3);

    // Top of the address space
    issueHeld(REQ_WRITE, 16'hFFFE, 16'hBEEF);
    idle(4);
    issueHeld(REQ_READ, 16'hFFFE, 16'h0);
    idle(3);

    // Random traffic over a pre-written address pool
    for (int i = 0; i < 16; i++) begin
      pool[i] = 16'($urandom) & 16'hFFFE;
      issueHeld(REQ_WRITE, pool[i], 16'($urandom));
    end
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 59);
      a = pool[$urandom_range(0, 15)];
      if (sel == 0) begin
        applyStimulus(REQ_READ, 1'b0, a, 16'h0, 1'b1, stalled);
      end else if (sel < 3) begin
        applyStimulus(REQ_NONE, 1'b1, a, 16'($urandom), 1'b0, stalled);
      end else if (sel < 5) begin
        k = (sel == 3) ? REQ_READ : REQ_WRITE;
        applyStimulus(k, 1'b0, a | 16'h0001, 16'($urandom), 1'b0, stalled);
      end else if (sel < 10) begin
        idle(1);
      end else if (sel < 35) begin
        issueHeld(REQ_READ, a, 16'h0);
      end else begin
        issueHeld(REQ_WRITE, a, 16'($urandom));
      end
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule
